// File: rtl/kan_pkg.sv
// Shared constants and types for the KAN kernel RAM read path.
package kan_pkg;
  localparam int PTR_WIDTH_DEF  = 12;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int RD_FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;
endpackage

// File: rtl/kernel_rd_fifo.sv
// Two-entry synchronous FIFO holding {last, data}; absorbs the RAM read latency.
module kernel_rd_fifo
  import kan_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [RD_FIFO_DEPTH-1:0][W-1:0] mem;
  logic                            wr_ptr, rd_ptr;
  logic                            do_pop;

  assign do_pop = pop & (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/kernel_ram_reader.sv
// Reads a contiguous block from the kernel RAM and streams it out in order.
module kernel_ram_reader
  import kan_pkg::*;
#(
  parameter int PTR_WIDTH  = PTR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PTR_WIDTH-1:0]  base_addr,
  input  logic [PTR_WIDTH:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ren,
  output logic [PTR_WIDTH-1:0]  ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  rd_state_e            state_q;
  logic [PTR_WIDTH-1:0] base_q;
  logic [PTR_WIDTH:0]   len_q, issued_q, popped_q;
  logic                 inflight_q, inflight_last_q;
  logic [1:0]           fcount;
  logic [DATA_WIDTH:0]  head;
  logic                 pop, issue_last;
  logic [2:0]           occ;

  assign pop        = m_valid & m_ready;
  assign m_valid    = (fcount != 2'd0);
  assign m_data     = head[DATA_WIDTH-1:0];
  assign m_last     = m_valid & head[DATA_WIDTH];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign ram_addrb  = base_q + issued_q[PTR_WIDTH-1:0];
  assign issue_last = (issued_q == len_q - 1'b1);

  // Occupancy counts the word still in the RAM pipe; a pop this cycle frees a slot early.
  assign occ     = {1'b0, fcount} + {2'b0, inflight_q};
  assign ram_ren = (state_q == RUN) && (issued_q < len_q) && (occ < (3'd2 + {2'b0, pop}));

  kernel_rd_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_dob}),
    .pop       (pop),
    .head      (head),
    .count     (fcount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      popped_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= ram_ren;
      inflight_last_q <= ram_ren & issue_last;
      if (pop) popped_q <= popped_q + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          base_q   <= base_addr;
          len_q    <= len;
          issued_q <= '0;
          popped_q <= '0;
          state_q  <= (len == '0) ? FIN : RUN;
        end
        RUN: begin
          if (ram_ren) issued_q <= issued_q + 1'b1;
          if (issued_q == len_q) state_q <= DRAIN;
        end
        // Leave once the last word has landed and is leaving the FIFO this cycle.
        DRAIN: if (!inflight_q && (popped_q + {{PTR_WIDTH{1'b0}}, pop}) == len_q)
          state_q <= FIN;
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
